// File: rtl/wb_pkg.sv
// Shared types and default sizes for the write-back commit buffer.
// Defaults here feed the parameter defaults of wb_commit_buffer.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;
    localparam int WB_DEPTH  = 4;

    // One queued write-back: register address and data, tagged valid while pending.
    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Combinational youngest-match search over the pending write-back entries.
// Slots are scanned in age order so that a later (younger) match overrides an earlier one.
module wb_bypass_match
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int DEPTH    = WB_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [PTR_W-1:0]             tail,
    input  logic [ADDR_W-1:0]            byp_addr,
    output logic                         byp_hit,
    output logic [DATA_W-1:0]            byp_data
);

    logic [PTR_W-1:0] idx;
    logic             zero_lookup;

    assign zero_lookup = (ZERO_REG != 0) && (byp_addr == '0);

    // Starting at tail walks the free slots first, then oldest to youngest,
    // so the final match seen is the youngest.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail + PTR_W'(i);
            if (valid[idx] && (addr[idx] == byp_addr) && !zero_lookup) begin
                byp_hit  = 1'b1;
                byp_data = data[idx];
            end
        end
    end

endmodule

// File: rtl/wb_commit_buffer.sv
// In-order write-back FIFO retiring to the shared register-file write port,
// with a forwarding lookup over the entries that are still pending.
module wb_commit_buffer
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int DEPTH    = WB_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_we,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        flush,
    input  logic                        rf_grant,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_addr,
    output logic [DATA_W-1:0]           rf_data,
    input  logic [ADDR_W-1:0]           byp_addr,
    output logic                        byp_hit,
    output logic [DATA_W-1:0]           byp_data,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             head_q;
    logic [PTR_W-1:0]             tail_q;
    logic [CNT_W-1:0]             count_q;
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    logic full;
    logic empty;
    logic zero_dest;
    logic store;
    logic retire;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign zero_dest = (ZERO_REG != 0) && (in_addr == '0);

    // Accepted requests that do not write (no-op or discarded r0) complete the
    // handshake without occupying a slot.
    assign store  = in_valid && in_ready && !flush && in_we && !zero_dest;
    assign retire = rf_we && rf_grant && !flush;

    assign rf_we   = !empty;
    assign rf_addr = empty ? '0 : addr_q[head_q];
    assign rf_data = empty ? '0 : data_q[head_q];
    assign count   = count_q;

    // Control state: flush shares the reset path so it beats enqueue and retire.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (store) begin
                tail_q          <= tail_q + 1'b1;
                valid_q[tail_q] <= 1'b1;
            end
            if (retire) begin
                head_q          <= head_q + 1'b1;
                valid_q[head_q] <= 1'b0;
            end
            case ({store, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset; it is only visible through the valid bits and count.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

    wb_bypass_match #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .PTR_W    (PTR_W)
    ) u_bypass (
        .valid    (valid_q),
        .addr     (addr_q),
        .data     (data_q),
        .tail     (tail_q),
        .byp_addr (byp_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data)
    );

endmodule
